sram_dp: RTL and testbench
==========================

SRAM_DP -- requirements
Module: sram_dp

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 12, address bits.
REQ-002 The module SHALL have parameter WORD_DEPTH, default 4096, number of words; legal range is 1 to 2^ADDR_WIDTH.
REQ-003 The module SHALL have parameter WORD_WIDTH, default 16, data bits per word.
REQ-004 The module SHALL have parameter BYTE_WIDTH, default 8, bits per write-enable lane; WORD_WIDTH is an integer multiple of it.
REQ-005 The module SHALL have parameter READ_LATENCY, default 1, read latency in cycles; legal values are 1 and 2.
REQ-006 The module SHALL have parameter CLEAR_ON_RESET, default 1; when 1, all words are zeroed after reset.
REQ-007 The module SHALL have one clock and synchronous active-low reset: clk  in  1  clock, all logic on posedge.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 i_we  in  1  write request.
REQ-010 i_waddr  in  ADDR_WIDTH  write address.
REQ-011 i_wdata  in  WORD_WIDTH  write data.
REQ-012 i_wbe  in  WORD_WIDTH/BYTE_WIDTH  byte-lane write enables; bit k enables i_wdata bits [k*BYTE_WIDTH +: BYTE_WIDTH].
REQ-013 i_re  in  1  read request.
REQ-014 i_raddr  in  ADDR_WIDTH  read address.
REQ-015 o_rdata  out  WORD_WIDTH  read data.
REQ-016 o_rvalid  out  1  o_rdata is valid this cycle.
REQ-017 o_busy  out  1  memory is clearing; requests are ignored.

Function
REQ-018 Controller states SHALL be ST_CLEAR and ST_READY; reset enters ST_CLEAR when CLEAR_ON_RESET=1, otherwise ST_READY.
REQ-019 In ST_CLEAR, a clear counter SHALL write all-zero to address 0..WORD_DEPTH-1, one word per cycle, then move to ST_READY; clearing takes exactly WORD_DEPTH cycles after rst_n deasserts.
REQ-020 o_busy SHALL be 1 exactly while in ST_CLEAR; i_we and i_re SHALL be ignored while o_busy=1.
REQ-021 Write: on a posedge with i_we=1, o_busy=0 and i_waddr<WORD_DEPTH, only the enabled byte lanes of mem[i_waddr] SHALL update; lanes with i_wbe=0 keep their value.
REQ-022 Read: a request accepted at edge N (i_re=1, o_busy=0) SHALL give o_rvalid=1 and o_rdata for exactly one cycle, starting after edge N+READ_LATENCY-1.
REQ-023 Back-to-back reads SHALL be accepted every cycle, giving one valid result per cycle in request order.
REQ-024 A read and write to the same address at the same edge SHALL be write-first: the enabled lanes come from i_wdata and the other lanes from the old word.
REQ-025 When READ_LATENCY=2, a write at edge N+1 to an address read at edge N SHALL NOT affect that read's result.
REQ-026 A write with i_waddr>=WORD_DEPTH SHALL be dropped; a read with i_raddr>=WORD_DEPTH SHALL return zero with o_rvalid=1.
REQ-027 o_rdata SHALL hold its last value while o_rvalid=0.
REQ-028 A write with i_wbe all-zero SHALL leave memory unchanged.

Reset
REQ-029 When rst_n=0 at a posedge, o_rvalid SHALL be 0, o_rdata SHALL be 0, the read pipeline SHALL be flushed and the clear counter SHALL be 0.
REQ-030 Reset during ST_CLEAR or during reads in flight SHALL restart clearing at address 0, and the in-flight results SHALL NOT appear.
REQ-031 Memory contents SHALL NOT be reset directly; they are zeroed only by ST_CLEAR.

Structure
REQ-032 Package sram_pkg SHALL hold the state enum (ST_CLEAR, ST_READY) and a byte-merge function (old word, new word, lane enables -> merged word).
REQ-033 Sub-module sram_init_ctrl SHALL contain the clear FSM and counter and output o_busy, clear address and clear write-enable; the storage array, bypass and read pipeline stay in sram_dp.

Verification
REQ-034 Default parameters, release rst_n -> o_busy=1 for exactly 4096 cycles; then a read of any of addresses 0, 2047 and 4095 returns 16'h0000.
REQ-035 Write 16'hABCD with i_wbe=2'b11 to address 5, then write 16'h1234 with i_wbe=2'b01 to address 5, then read address 5 -> 16'hAB34 with o_rvalid one cycle after the read request.
REQ-036 Same edge: write 16'h5A5A with i_wbe=2'b10 and read address 7, which holds 16'h1111 -> o_rdata=16'h5A11.
REQ-037 READ_LATENCY=2, reads of addresses 1, 2, 3 on consecutive cycles -> three consecutive o_rvalid pulses with the data in order, starting two cycles after the first request.
REQ-038 WORD_DEPTH=100: write to address 100 then read address 100 -> read returns 0 with o_rvalid=1; address 99 is unchanged.
REQ-039 Assert rst_n=0 at clear address 50 with a read in flight -> no o_rvalid pulse; clearing restarts at 0; o_busy stays high for WORD_DEPTH cycles after release.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the dual-port SRAM: controller state
// encoding and the byte-lane merge used for write-first read bypass.
package sram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

  // The merge helper works on a fixed wide container so any legal word and
  // lane configuration fits; callers widen on the way in and slice on the
  // way out.
  localparam int MERGE_MAX_W = 256;

  typedef logic [MERGE_MAX_W-1:0] merge_word_t;
  typedef logic [MERGE_MAX_W-1:0] merge_be_t;

  // Returns old_word with every lane whose enable is set replaced by the
  // corresponding lane of new_word. lane_width is the bit width of a lane.
  function automatic merge_word_t byte_merge(
    input merge_word_t old_word,
    input merge_word_t new_word,
    input merge_be_t   lane_en,
    input int          lane_width
  );
    merge_word_t res;
    for (int b = 0; b < MERGE_MAX_W; b++) begin
      res[b] = lane_en[b / lane_width] ? new_word[b] : old_word[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Clear controller: after reset walks every word address once, issuing a
// zero write per cycle, and reports busy until the walk completes.
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int WORD_DEPTH     = 4096,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_clr_addr,
  output logic                  o_clr_we
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam sram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // State and clear counter registers; reset restarts the walk at address 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and clear write strobe; one word is zeroed per cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    o_clr_we = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // No writes are issued while reset is still asserted.
        o_clr_we = rst_n;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  assign o_busy     = (state_q == ST_CLEAR);
  assign o_clr_addr = cnt_q;

endmodule

// File: rtl/sram_dp.sv
// Simple dual-port SRAM (one write port, one read port) with byte-lane
// write enables, write-first same-address bypass, 1- or 2-cycle read
// latency and optional zero-fill after reset.
module sram_dp
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int WORD_DEPTH     = 4096,
  parameter int WORD_WIDTH     = 16,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_we,
  input  logic [ADDR_WIDTH-1:0]            i_waddr,
  input  logic [WORD_WIDTH-1:0]            i_wdata,
  input  logic [WORD_WIDTH/BYTE_WIDTH-1:0] i_wbe,
  input  logic                             i_re,
  input  logic [ADDR_WIDTH-1:0]            i_raddr,
  output logic [WORD_WIDTH-1:0]            o_rdata,
  output logic                             o_rvalid,
  output logic                             o_busy
);

  localparam int LANES = WORD_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(WORD_DEPTH);

  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sram_init_ctrl #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .WORD_DEPTH    (WORD_DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_init_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .o_busy    (busy),
    .o_clr_addr(clr_addr),
    .o_clr_we  (clr_we)
  );

  assign o_busy = busy;

  // Request qualification: nothing is accepted in reset or while clearing.
  logic w_in_range, r_in_range, wr_acc, rd_acc;
  assign w_in_range = ({1'b0, i_waddr} < DEPTH_EXT);
  assign r_in_range = ({1'b0, i_raddr} < DEPTH_EXT);
  assign wr_acc     = rst_n & ~busy & i_we & w_in_range;
  assign rd_acc     = rst_n & ~busy & i_re;

  // Single physical write port shared by the clear walk and user writes.
  logic                  port_we;
  logic [ADDR_WIDTH-1:0] port_addr;
  logic [WORD_WIDTH-1:0] port_data;
  logic [LANES-1:0]      port_be;

  // Clear writes take the port whenever the controller requests it.
  always_comb begin
    port_we   = wr_acc;
    port_addr = i_waddr;
    port_data = i_wdata;
    port_be   = i_wbe;
    if (clr_we) begin
      port_we   = 1'b1;
      port_addr = clr_addr;
      port_data = '0;
      port_be   = '1;
    end
  end

  // Storage is split per byte lane so each lane maps onto its own RAM
  // column with a plain write enable and a registered read.
  logic [WORD_WIDTH-1:0] mem_rd;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [BYTE_WIDTH-1:0] lane_mem [WORD_DEPTH];
    logic [BYTE_WIDTH-1:0] lane_rd_q;

    // One lane of storage; the read returns the pre-write contents.
    always_ff @(posedge clk) begin
      if (port_we && port_be[gi]) begin
        lane_mem[port_addr] <= port_data[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (rd_acc) begin
        lane_rd_q <= lane_mem[i_raddr];
      end
    end

    assign mem_rd[gi*BYTE_WIDTH +: BYTE_WIDTH] = lane_rd_q;
  end

  // Stage-1 side information travelling alongside the RAM read.
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_oob_q, s1_oob_d;
  logic                  s1_hit_q, s1_hit_d;
  logic [WORD_WIDTH-1:0] s1_wdata_q, s1_wdata_d;
  logic [LANES-1:0]      s1_wbe_q, s1_wbe_d;
  logic [WORD_WIDTH-1:0] s1_word;

  // Capture whether this read collides with a same-edge write (bypass).
  always_comb begin
    s1_valid_d = rd_acc;
    s1_oob_d   = ~r_in_range;
    s1_hit_d   = wr_acc & (i_waddr == i_raddr);
    s1_wdata_d = i_wdata;
    s1_wbe_d   = i_wbe;
  end

  // Stage-1 registers; reset flushes any read in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_oob_q   <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_wdata_q <= '0;
      s1_wbe_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_oob_q   <= s1_oob_d;
      s1_hit_q   <= s1_hit_d;
      s1_wdata_q <= s1_wdata_d;
      s1_wbe_q   <= s1_wbe_d;
    end
  end

  // Resolved read word: zero for out-of-range, write-first merge on collision.
  always_comb begin
    s1_word = mem_rd;
    if (s1_oob_q) begin
      s1_word = '0;
    end else if (s1_hit_q) begin
      s1_word = WORD_WIDTH'(byte_merge(merge_word_t'(mem_rd), merge_word_t'(s1_wdata_q),
                                       merge_be_t'(s1_wbe_q), BYTE_WIDTH));
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    logic [WORD_WIDTH-1:0] hold_q, hold_d;

    // Output follows the fresh word when valid, otherwise the last one.
    always_comb begin
      hold_d = hold_q;
      if (s1_valid_q) begin
        hold_d = s1_word;
      end
    end

    // Last delivered word, cleared by reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hold_q <= '0;
      end else begin
        hold_q <= hold_d;
      end
    end

    assign o_rvalid = s1_valid_q;
    assign o_rdata  = hold_d;
  end else begin : g_lat2
    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] out_data_q, out_data_d;

    // Second pipeline stage; data only moves when a result arrives.
    always_comb begin
      out_valid_d = s1_valid_q;
      out_data_d  = out_data_q;
      if (s1_valid_q) begin
        out_data_d = s1_word;
      end
    end

    // Output registers, cleared by reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
      end
    end

    assign o_rvalid = out_valid_q;
    assign o_rdata  = out_data_q;
  end

endmodule

// File: tb/tb_sram_dp.sv
// Bench for sram_dp: instance A uses default parameters, instance B uses
// WORD_DEPTH=100, ADDR_WIDTH=8, READ_LATENCY=2. Both see the same inputs
// and are checked against a word-level reference model.
module tb_sram_dp;

  logic        clk;
  logic        rst_n;
  logic        i_we;
  logic [11:0] i_waddr;
  logic [15:0] i_wdata;
  logic [1:0]  i_wbe;
  logic        i_re;
  logic [11:0] i_raddr;
  logic [15:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  sram_dp u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .i_wbe(i_wbe), .i_re(i_re), .i_raddr(i_raddr), .o_rdata(rdata_a),
    .o_rvalid(rvalid_a), .o_busy(busy_a)
  );

  sram_dp #(
    .ADDR_WIDTH(8), .WORD_DEPTH(100), .WORD_WIDTH(16), .BYTE_WIDTH(8),
    .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_we(i_we), .i_waddr(i_waddr[7:0]), .i_wdata(i_wdata),
    .i_wbe(i_wbe), .i_re(i_re), .i_raddr(i_raddr[7:0]), .o_rdata(rdata_b),
    .o_rvalid(rvalid_b), .o_busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [15:0] d;
  } res_t;

  res_t        mq0[$];
  res_t        mq1[$];
  logic [15:0] mmem[2][4096];
  int          clr_left[2];
  logic        ev[2];
  logic [15:0] ed[2];
  logic        eb[2];
  int          cyc = 0;

  function automatic logic [15:0] mrg(input logic [15:0] o, input logic [15:0] n,
                                      input logic [1:0] be);
    return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
  endfunction

  task automatic model_edge(input int m);
    int d, lat, wa, ra;
    logic [15:0] v;
    res_t q[$];
    res_t r;
    d   = (m == 0) ? 4096 : 100;
    lat = (m == 0) ? 1 : 2;
    wa  = (m == 0) ? int'(i_waddr) : int'(i_waddr[7:0]);
    ra  = (m == 0) ? int'(i_raddr) : int'(i_raddr[7:0]);
    if (m == 0) q = mq0; else q = mq1;
    if (!rst_n) begin
      q.delete();
      clr_left[m] = d;
      ev[m] = 1'b0;
      ed[m] = 16'h0;
    end else begin
      if (clr_left[m] > 0) begin
        mmem[m][d - clr_left[m]] = 16'h0;
        clr_left[m]--;
      end else begin
        if (i_re) begin
          if (ra >= d) v = 16'h0;
          else if (i_we && wa == ra) v = mrg(mmem[m][ra], i_wdata, i_wbe);
          else v = mmem[m][ra];
          r.due = cyc + lat - 1;
          r.d   = v;
          q.push_back(r);
        end
        if (i_we && wa < d) mmem[m][wa] = mrg(mmem[m][wa], i_wdata, i_wbe);
      end
      ev[m] = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ev[m] = 1'b1;
        ed[m] = q[0].d;
        void'(q.pop_front());
      end
    end
    eb[m] = (clr_left[m] > 0);
    if (m == 0) mq0 = q; else mq1 = q;
  endtask

  always @(posedge clk) begin
    cyc++;
    model_edge(0);
    model_edge(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input int wa, input logic [15:0] wd,
                       input logic [1:0] be, input logic re, input int ra);
    i_we    = we;
    i_waddr = 12'(wa);
    i_wdata = wd;
    i_wbe   = be;
    i_re    = re;
    i_raddr = 12'(ra);
  endtask

  task automatic idle();
    drive(1'b0, 0, 16'h0, 2'b00, 1'b0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (3) step();
    checks++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got a=%b b=%b expected 1 1", busy_a, busy_b);
    end
    checks++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || rdata_a !== 16'h0 || rdata_b !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rvalid=%b/%b rdata=%h/%h expected 0/0 0000/0000",
               rvalid_a, rvalid_b, rdata_a, rdata_b);
    end
    rst_n = 1'b1;
  endtask

  // Counts busy cycles from the release point; random requests while busy.
  task automatic test_clear(input int rand_cycles, input int exp_a, input int exp_b);
    int cnt_a = 0;
    int cnt_b = 0;
    for (int i = 0; i < 5000 && (busy_a === 1'b1 || busy_b === 1'b1); i++) begin
      if (busy_a === 1'b1) cnt_a++;
      if (busy_b === 1'b1) cnt_b++;
      checks++;
      if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
        errors++;
        $display("FAIL clear_no_rvalid: cycle %0d got %b/%b expected 0/0", i, rvalid_a, rvalid_b);
      end
      if (i < rand_cycles)
        drive(1'($urandom), int'($urandom_range(0, 4095)), 16'($urandom), 2'($urandom),
              1'($urandom), int'($urandom_range(0, 4095)));
      else
        idle();
      step();
    end
    idle();
    checks++;
    if (cnt_a != exp_a || cnt_b != exp_b) begin
      errors++;
      $display("FAIL clear_busy_cycles: got a=%0d b=%0d expected a=%0d b=%0d",
               cnt_a, cnt_b, exp_a, exp_b);
    end
  endtask

  task automatic test_zero_after_clear();
    int addrs[3] = '{0, 2047, 4095};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, 16'h0, 2'b00, 1'b1, addrs[i]);
      step();
      checks++;
      if (rvalid_a !== 1'b1 || rdata_a !== 16'h0000) begin
        errors++;
        $display("FAIL zero_read_a[%0d]: got rvalid=%b rdata=%h expected 1 0000",
                 addrs[i], rvalid_a, rdata_a);
      end
    end
    idle();
    step();
    checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== 16'h0000) begin
      errors++;
      $display("FAIL zero_read_b: got rvalid=%b rdata=%h expected 1 0000", rvalid_b, rdata_b);
    end
  endtask

  task automatic test_byte_write();
    drive(1'b1, 5, 16'hABCD, 2'b11, 1'b0, 0); step();
    drive(1'b1, 5, 16'h1234, 2'b01, 1'b0, 0); step();
    drive(1'b0, 0, 16'h0, 2'b00, 1'b1, 5);    step();
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== 16'hAB34) begin
      errors++;
      $display("FAIL byte_write_a: got rvalid=%b rdata=%h expected 1 ab34", rvalid_a, rdata_a);
    end
    idle(); step();
    checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== 16'hAB34) begin
      errors++;
      $display("FAIL byte_write_b: got rvalid=%b rdata=%h expected 1 ab34", rvalid_b, rdata_b);
    end
    checks++;
    if (rvalid_a !== 1'b0 || rdata_a !== 16'hAB34) begin
      errors++;
      $display("FAIL rdata_hold_a: got rvalid=%b rdata=%h expected 0 ab34", rvalid_a, rdata_a);
    end
  endtask

  task automatic test_write_first();
    drive(1'b1, 7, 16'h1111, 2'b11, 1'b0, 0); step();
    drive(1'b1, 7, 16'h5A5A, 2'b10, 1'b1, 7); step();
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== 16'h5A11) begin
      errors++;
      $display("FAIL write_first_a: got rvalid=%b rdata=%h expected 1 5a11", rvalid_a, rdata_a);
    end
    idle(); step();
    checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== 16'h5A11) begin
      errors++;
      $display("FAIL write_first_b: got rvalid=%b rdata=%h expected 1 5a11", rvalid_b, rdata_b);
    end
  endtask

  task automatic test_rl2_pipeline();
    logic [15:0] exp_b[5] = '{16'h0, 16'hA001, 16'hA002, 16'hA003, 16'h0};
    logic        expv_b[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, i, 16'hA000 + 16'(i), 2'b11, 1'b0, 0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      drive(1'b0, 0, 16'h0, 2'b00, 1'b1, 1);
      else if (i == 1) drive(1'b1, 1, 16'hFFFF, 2'b11, 1'b1, 2);
      else if (i == 2) drive(1'b0, 0, 16'h0, 2'b00, 1'b1, 3);
      else             idle();
      step();
      checks++;
      if (rvalid_b !== expv_b[i] || (expv_b[i] && rdata_b !== exp_b[i])) begin
        errors++;
        $display("FAIL rl2_pipe[%0d]: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                 i, rvalid_b, rdata_b, expv_b[i], exp_b[i]);
      end
    end
    checks++;
    if (rdata_b !== 16'hA003) begin
      errors++;
      $display("FAIL rl2_hold: got %h expected a003", rdata_b);
    end
  endtask

  task automatic test_oob();
    drive(1'b1, 99, 16'h9999, 2'b11, 1'b0, 0);  step();
    drive(1'b1, 100, 16'hBEEF, 2'b11, 1'b0, 0); step();
    drive(1'b0, 0, 16'h0, 2'b00, 1'b1, 100);    step();
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== 16'hBEEF) begin
      errors++;
      $display("FAIL oob_inrange_a: got rvalid=%b rdata=%h expected 1 beef", rvalid_a, rdata_a);
    end
    drive(1'b0, 0, 16'h0, 2'b00, 1'b1, 99); step();
    checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== 16'h0000) begin
      errors++;
      $display("FAIL oob_read_b: got rvalid=%b rdata=%h expected 1 0000", rvalid_b, rdata_b);
    end
    idle(); step();
    checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== 16'h9999) begin
      errors++;
      $display("FAIL oob_neighbour_b: got rvalid=%b rdata=%h expected 1 9999", rvalid_b, rdata_b);
    end
  endtask

  task automatic test_wbe_zero();
    drive(1'b1, 5, 16'hFFFF, 2'b00, 1'b0, 0); step();
    drive(1'b0, 0, 16'h0, 2'b00, 1'b1, 5);    step();
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== 16'hAB34) begin
      errors++;
      $display("FAIL wbe_zero_a: got rvalid=%b rdata=%h expected 1 ab34", rvalid_a, rdata_a);
    end
    idle(); step();
  endtask

  task automatic test_random(input int n);
    int wa, ra;
    for (int i = 0; i < n; i++) begin
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(90, 110));
      ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(90, 110));
      drive(1'($urandom), wa, 16'($urandom), 2'($urandom), 1'($urandom), ra);
      step();
      checks++;
      if (busy_a !== eb[0] || rvalid_a !== ev[0] || rdata_a !== ed[0]) begin
        errors++;
        $display("FAIL random_a[%0d]: got busy=%b rvalid=%b rdata=%h expected %b %b %h",
                 i, busy_a, rvalid_a, rdata_a, eb[0], ev[0], ed[0]);
      end
      checks++;
      if (busy_b !== eb[1] || rvalid_b !== ev[1] || rdata_b !== ed[1]) begin
        errors++;
        $display("FAIL random_b[%0d]: got busy=%b rvalid=%b rdata=%h expected %b %b %h",
                 i, busy_b, rvalid_b, rdata_b, eb[1], ev[1], ed[1]);
      end
    end
    idle();
    step();
    step();
  endtask

  task automatic test_reset_midclear();
    drive(1'b1, 60, 16'h6060, 2'b11, 1'b0, 0); step();
    drive(1'b0, 0, 16'h0, 2'b00, 1'b1, 60);    step();
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== 16'h6060 || rvalid_b !== 1'b0) begin
      errors++;
      $display("FAIL inflight_pre: got a=%b/%h b=%b expected 1/6060 0", rvalid_a, rdata_a, rvalid_b);
    end
    idle();
    rst_n = 1'b0;
    step();
    checks++;
    if (rvalid_b !== 1'b0 || rdata_b !== 16'h0 || rvalid_a !== 1'b0 || rdata_a !== 16'h0) begin
      errors++;
      $display("FAIL inflight_flush: got b=%b/%h a=%b/%h expected 0/0000 0/0000",
               rvalid_b, rdata_b, rvalid_a, rdata_a);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (busy_b !== 1'b1 || rvalid_b !== 1'b0) begin
        errors++;
        $display("FAIL midclear_busy[%0d]: got busy=%b rvalid=%b expected 1 0", i, busy_b, rvalid_b);
      end
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    test_clear(0, 4096, 100);
    drive(1'b0, 0, 16'h0, 2'b00, 1'b1, 60); step();
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== 16'h0000) begin
      errors++;
      $display("FAIL recleared_a: got rvalid=%b rdata=%h expected 1 0000", rvalid_a, rdata_a);
    end
    idle(); step();
    checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== 16'h0000) begin
      errors++;
      $display("FAIL recleared_b: got rvalid=%b rdata=%h expected 1 0000", rvalid_b, rdata_b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_clear(60, 4096, 100);
    test_zero_after_clear();
    test_byte_write();
    test_write_first();
    test_rl2_pipeline();
    test_oob();
    test_wbe_zero();
    test_random(2000);
    test_reset_midclear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
